// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// clear-sequencer state encodings and read-source (lane) selects.
package reg_file_pkg;

    localparam int WORD_SIZE_DEF = 32;
    localparam int ADDR_SIZE_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    typedef enum logic [1:0] {
        SRC_ARRAY  = 2'd0,
        SRC_LANE_A = 2'd1,
        SRC_LANE_B = 2'd2,
        SRC_ZERO   = 2'd3
    } rd_src_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Run-time clear sequencer: sweeps every entry once, one per clock,
// after a clear request seen while idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | normal operation, i_clr sampled each edge
// ST_CLEAR | entry[cnt] zeroed each edge, writes and bypass suppressed
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    output logic                 o_busy,
    output logic                 o_clr_en,
    output logic [ADDR_SIZE-1:0] o_clr_addr
);

    localparam logic [ADDR_SIZE:0] CNT_LAST = (ADDR_SIZE+1)'((2**ADDR_SIZE) - 1);

    clr_state_e         state_q, state_d;
    logic [ADDR_SIZE:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Terminal entry is cleared on the same edge that returns to idle.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_busy     = (state_q == ST_CLEAR);
    assign o_clr_en   = (state_q == ST_CLEAR);
    assign o_clr_addr = cnt_q[ADDR_SIZE-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// lanes (B wins on collision), optional bypass and hardwired zero register.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_RD*ADDR_SIZE-1:0] i_rd_reg,
    output logic [NUM_RD*WORD_SIZE-1:0] o_rd_data,
    input  logic [ADDR_SIZE-1:0]        i_wr_reg_a,
    input  logic [WORD_SIZE-1:0]        i_wr_data_a,
    input  logic                        i_reg_wr_a,
    input  logic [ADDR_SIZE-1:0]        i_wr_reg_b,
    input  logic [WORD_SIZE-1:0]        i_wr_data_b,
    input  logic                        i_reg_wr_b,
    input  logic                        i_clr,
    output logic                        o_busy
);

    localparam int DEPTH = 2**ADDR_SIZE;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] mem_d [DEPTH];
    logic                 busy;
    logic                 clr_en;
    logic [ADDR_SIZE-1:0] clr_addr;
    logic                 wr_a_ok, wr_b_ok;

    reg_file_clr_seq #(.ADDR_SIZE(ADDR_SIZE)) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .o_busy     (busy),
        .o_clr_en   (clr_en),
        .o_clr_addr (clr_addr)
    );

    assign o_busy  = busy;
    assign wr_a_ok = i_reg_wr_a && !busy && !((ZERO_REG != 0) && (i_wr_reg_a == '0));
    assign wr_b_ok = i_reg_wr_b && !busy && !((ZERO_REG != 0) && (i_wr_reg_b == '0));

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else begin
            // Lane B applied last so it wins on an address collision.
            if (wr_a_ok) mem_d[i_wr_reg_a] = i_wr_data_a;
            if (wr_b_ok) mem_d[i_wr_reg_b] = i_wr_data_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_SIZE-1:0] rd_addr;
        logic [WORD_SIZE-1:0] rd_val;
        rd_src_e              src;

        assign rd_addr = i_rd_reg[k*ADDR_SIZE +: ADDR_SIZE];

        always_comb begin
            src = SRC_ARRAY;
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                src = SRC_ZERO;
            end else if ((BYPASS != 0) && !busy) begin
                if (i_reg_wr_b && (i_wr_reg_b == rd_addr))      src = SRC_LANE_B;
                else if (i_reg_wr_a && (i_wr_reg_a == rd_addr)) src = SRC_LANE_A;
            end
        end

        always_comb begin
            rd_val = mem_q[rd_addr];
            case (src)
                SRC_LANE_A: rd_val = i_wr_data_a;
                SRC_LANE_B: rd_val = i_wr_data_b;
                SRC_ZERO:   rd_val = '0;
                default:    rd_val = mem_q[rd_addr];
            endcase
        end

        assign o_rd_data[k*WORD_SIZE +: WORD_SIZE] = rd_val;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with bypass, one without,
// sharing all inputs.
module tb_reg_file_mp;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [9:0]  i_rd_reg;
    logic [63:0] rd_bp, rd_nb;
    logic [4:0]  i_wr_reg_a, i_wr_reg_b;
    logic [31:0] i_wr_data_a, i_wr_data_b;
    logic        i_reg_wr_a, i_reg_wr_b;
    logic        i_clr;
    logic        busy_bp, busy_nb;

    int n_chk = 0;
    int n_err = 0;
    int busy_cycles;

    always #5 i_clk = ~i_clk;

    reg_file_mp #(.BYPASS(1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rd_reg(i_rd_reg), .o_rd_data(rd_bp),
        .i_wr_reg_a(i_wr_reg_a), .i_wr_data_a(i_wr_data_a), .i_reg_wr_a(i_reg_wr_a),
        .i_wr_reg_b(i_wr_reg_b), .i_wr_data_b(i_wr_data_b), .i_reg_wr_b(i_reg_wr_b),
        .i_clr(i_clr), .o_busy(busy_bp)
    );

    reg_file_mp #(.BYPASS(0)) u_dut_nb (
        .i_clk(i_clk), .i_rst(i_rst), .i_rd_reg(i_rd_reg), .o_rd_data(rd_nb),
        .i_wr_reg_a(i_wr_reg_a), .i_wr_data_a(i_wr_data_a), .i_reg_wr_a(i_reg_wr_a),
        .i_wr_reg_b(i_wr_reg_b), .i_wr_data_b(i_wr_data_b), .i_reg_wr_b(i_reg_wr_b),
        .i_clr(i_clr), .o_busy(busy_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        i_rd_reg = {5'(a1), 5'(a0)};
    endtask

    task automatic write_a(input int addr, input logic [31:0] data);
        i_reg_wr_a  = 1'b1;
        i_wr_reg_a  = 5'(addr);
        i_wr_data_a = data;
    endtask

    task automatic write_b(input int addr, input logic [31:0] data);
        i_reg_wr_b  = 1'b1;
        i_wr_reg_b  = 5'(addr);
        i_wr_data_b = data;
    endtask

    task automatic idle_wr();
        i_reg_wr_a = 1'b0;
        i_reg_wr_b = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0; i_clr = 1'b0; i_rd_reg = '0;
        i_wr_reg_a = '0; i_wr_data_a = '0; i_wr_reg_b = '0; i_wr_data_b = '0;
        idle_wr();

        // Reset state
        @(negedge i_clk);
        set_rd(5, 31); #1;
        check("rst_busy", 32'(busy_bp), 32'd0);
        check("rst_rd0", rd_bp[31:0], 32'd0);
        check("rst_rd1", rd_bp[63:32], 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a); #1;
            check("init_p0", rd_bp[31:0], 32'd0);
            check("init_p1", rd_bp[63:32], 32'd0);
        end
        check("init_busy", 32'(busy_bp), 32'd0);

        // Single write with same-cycle bypass
        @(negedge i_clk);
        write_a(5, 32'hDEADBEEF); set_rd(5, 6); #1;
        check("byp_a_p0", rd_bp[31:0], 32'hDEADBEEF);
        check("byp_a_p1_other", rd_bp[63:32], 32'd0);
        check("nobyp_a_p0", rd_nb[31:0], 32'd0);
        @(negedge i_clk);
        idle_wr(); #1;
        check("wr_a_bp", rd_bp[31:0], 32'hDEADBEEF);
        check("wr_a_nb", rd_nb[31:0], 32'hDEADBEEF);

        // Same-address collision: lane B wins
        write_a(9, 32'h1111); write_b(9, 32'h2222); set_rd(9, 9); #1;
        check("coll_byp_p0", rd_bp[31:0], 32'h2222);
        check("coll_byp_p1", rd_bp[63:32], 32'h2222);
        check("coll_nb", rd_nb[31:0], 32'd0);
        @(negedge i_clk);
        idle_wr(); #1;
        check("coll_bp", rd_bp[31:0], 32'h2222);
        check("coll_nb_stored", rd_nb[63:32], 32'h2222);

        // Different addresses: both commit
        write_a(3, 32'h33); write_b(4, 32'h44); set_rd(3, 4); #1;
        check("dual_byp_a", rd_bp[31:0], 32'h33);
        check("dual_byp_b", rd_bp[63:32], 32'h44);
        check("dual_nb_a", rd_nb[31:0], 32'd0);
        @(negedge i_clk);
        idle_wr(); #1;
        check("dual_a", rd_bp[31:0], 32'h33);
        check("dual_b", rd_bp[63:32], 32'h44);
        check("dual_nb_b", rd_nb[63:32], 32'h44);

        // Zero register: write dropped, no bypass
        write_a(0, 32'hFFFFFFFF); write_b(0, 32'hFFFFFFFF); set_rd(0, 0); #1;
        check("zero_byp_p0", rd_bp[31:0], 32'd0);
        check("zero_byp_p1", rd_bp[63:32], 32'd0);
        @(negedge i_clk);
        idle_wr(); #1;
        check("zero_after", rd_bp[31:0], 32'd0);
        check("zero_after_nb", rd_nb[63:32], 32'd0);

        // Fill 1..31 with index+64
        for (int i = 1; i < 32; i++) begin
            write_a(i, 32'(i + 64));
            @(negedge i_clk);
        end
        idle_wr(); set_rd(31, 5); #1;
        check("fill_31", rd_bp[31:0], 32'd95);
        check("fill_5", rd_bp[63:32], 32'd69);
        check("fill_nb_31", rd_nb[31:0], 32'd95);

        // Clear sweep with a dropped mid-clear write
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!busy_bp) break;
            busy_cycles++;
            if (busy_cycles == 6) begin
                write_a(2, 32'hABCD); set_rd(20, 2); #1;
                check("mid_clr_p0_unswept", rd_bp[31:0], 32'd84);
                check("mid_clr_p1_nobyp", rd_bp[63:32], 32'd0);
                check("mid_clr_busy_nb", 32'(busy_nb), 32'd1);
            end
            @(negedge i_clk);
            idle_wr();
        end
        check("clr_busy_cycles", 32'(busy_cycles), 32'd32);
        check("clr_busy_nb_low", 32'(busy_nb), 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a); #1;
            check("post_clr_bp", rd_bp[31:0], 32'd0);
            check("post_clr_nb", rd_nb[63:32], 32'd0);
        end

        // First write after clear
        write_a(7, 32'h77); write_b(12, 32'hC0);
        @(negedge i_clk);
        idle_wr(); set_rd(7, 12); #1;
        check("post_clr_wr7", rd_bp[31:0], 32'h77);
        check("post_clr_wr12", rd_bp[63:32], 32'hC0);
        check("post_clr_wr7_nb", rd_nb[31:0], 32'h77);

        // Async reset in the middle of a clear
        @(negedge i_clk);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (busy_bp) busy_cycles++;
            if (busy_cycles == 10) break;
            @(negedge i_clk);
        end
        check("rstclr_reached", 32'(busy_cycles), 32'd10);
        #1 i_rst = 1'b0;
        #1;
        check("rstclr_busy", 32'(busy_bp), 32'd0);
        check("rstclr_busy_nb", 32'(busy_nb), 32'd0);
        set_rd(31, 12); #1;
        check("rstclr_rd31", rd_bp[31:0], 32'd0);
        check("rstclr_rd12", rd_bp[63:32], 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        set_rd(7, 12); #1;
        check("rstclr_idle", 32'(busy_bp), 32'd0);
        check("rstclr_rd7", rd_bp[31:0], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the datapath. It is the successor of the 2-read/1-write register file, generalised to N read ports and two write ports. It adds write-to-read bypass, an optional hardwired zero register, and a run-time clear sequencer. It sits between decode (read addresses) and writeback (two retire lanes); CONTROL drives the write enables and the clear request.

Parameters:
WORD_SIZE, 32, bits per register
ADDR_SIZE, 5, address width; depth = 2**ADDR_SIZE
NUM_RD, 2, number of read ports (1..8)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_rd_reg  in  NUM_RD*ADDR_SIZE  packed read addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
o_rd_data  out  NUM_RD*WORD_SIZE  packed read data, port k at [k*WORD_SIZE +: WORD_SIZE]
i_wr_reg_a  in  ADDR_SIZE  write address, lane A
i_wr_data_a  in  WORD_SIZE  write data, lane A
i_reg_wr_a  in  1  write enable, lane A
i_wr_reg_b  in  ADDR_SIZE  write address, lane B
i_wr_data_b  in  WORD_SIZE  write data, lane B
i_reg_wr_b  in  1  write enable, lane B
i_clr  in  1  clear request (level-sampled while idle)
o_busy  out  1  clear sequence in progress

Behaviour:
- Reset (i_rst=0, async): all entries 0, FSM=IDLE, clear counter 0, o_busy=0; all o_rd_data read 0.
- Writes: committed on posedge when enable=1 and FSM=IDLE. Both lanes enabled with the same address: lane B wins. Different addresses: both commit.
- Reads: combinational from the array; a committed write is visible on the cycle after the edge.
- BYPASS=1, FSM=IDLE: a read address equal to an enabled write address in the same cycle returns that write data (lane B over lane A). BYPASS=0: returns the stored value.
- ZERO_REG=1: writes to address 0 dropped; reads of address 0 return 0 on every port, with no bypass. ZERO_REG=0: entry 0 behaves like any other entry.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR: on posedge with i_clr=1; counter loaded with 0.
  - CLEAR: each posedge zeroes entry[counter], then counter+1.
  - CLEAR→IDLE: on the edge that clears entry 2**ADDR_SIZE-1. The clear takes exactly 2**ADDR_SIZE cycles.
  - o_busy=1 exactly while state=CLEAR (registered). First write accepted on the edge after o_busy falls.
- While CLEAR: both write enables ignored (writes lost, not queued); bypass disabled; reads return current array contents (partially cleared); i_clr ignored.
- i_clr and a write on the same IDLE edge: the write commits, CLEAR starts, and the sweep later zeroes it.
- Reset mid-clear: immediate return to IDLE; array already 0.
- Counter is ADDR_SIZE+1 bits, so terminal detection never wraps.

Decomposition:
- Shared package/header reg_file_pkg: WORD_SIZE/ADDR_SIZE defaults, FSM state encodings (ST_IDLE=0, ST_CLEAR=1), lane-select constants.
- One sub-module, reg_file_clr_seq: FSM plus counter.
  - Inputs: i_clk, i_rst, i_clr.
  - Outputs: o_busy, o_clr_en, o_clr_addr.
- The top holds the array, the write arbitration and the per-port read/bypass mux (generate loop over NUM_RD).

Test Plan:
- Release reset, read addresses 0..31 on both ports → all 0; o_busy=0.
- Write A: reg 5=0xDEADBEEF; next cycle read port 0 addr 5 → 0xDEADBEEF. Same cycle with BYPASS=1 → 0xDEADBEEF; with BYPASS=0 → 0.
- Both lanes write reg 9 (A=0x1111, B=0x2222) → reg 9 reads 0x2222. Lanes write reg 3 (A=0x33) and reg 4 (B=0x44) → both stored.
- Write 0xFFFFFFFF to reg 0 with ZERO_REG=1 → reads 0, including same-cycle bypass.
- Fill regs 1..31 with index+64, pulse i_clr:
  - o_busy high for exactly 32 cycles.
  - A write issued mid-clear is dropped.
  - Afterwards all reads return 0 and a write to reg 7 succeeds.
- Assert i_rst=0 at clear cycle 10 between clock edges → o_busy falls immediately (async), and all reads return 0.
